// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: mode encoding and
// the signed-overflow rule.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // b_msb is the raw operand MSB (before SUB inversion).
  function automatic logic ovf_f(input logic a_msb, input logic b_msb,
                                 input logic s_msb, input logic mode);
    logic sign_match;
    sign_match = (mode == MODE_SUB) ? (a_msb != b_msb) : (a_msb == b_msb);
    return sign_match && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice with carry-in and carry-out.
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned CW = CHUNK + 1;

  logic [CW-1:0] total;

  always_comb begin
    total = CW'(a_i) + CW'(b_i) + CW'(cin_i);
  end

  assign sum_o  = total[CHUNK-1:0];
  assign cout_o = total[CHUNK];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one CHUNK-bit carry slice is resolved per stage,
// with valid/ready handshakes at both ends and carry/overflow/zero flags.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;

  // The whole pipeline moves as one; a held result freezes every stage behind it.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned RW = WIDTH - k * CHUNK;  // operand bits not yet resolved
    localparam int unsigned SW = (k + 1) * CHUNK;    // result bits resolved so far

    logic [RW-1:0]    a_src;
    logic [RW-1:0]    b_src;
    logic             v_src;
    logic             m_src;
    logic             c_src;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic [SW-1:0]    sum_d, sum_q;
    logic             vld_d, vld_q;
    logic             mode_d, mode_q;
    logic             cy_d, cy_q;

    if (k == 0) begin : g_first
      // SUB inverts B and forces the carry-in to 1, so every slice only adds.
      always_comb begin
        v_src = in_valid;
        m_src = in_mode;
        a_src = in_a;
        b_src = (in_mode == MODE_SUB) ? ~in_b : in_b;
        c_src = (in_mode == MODE_SUB) ? 1'b1 : in_cin;
      end
      assign sum_d = slice_sum;
    end else begin : g_next
      always_comb begin
        v_src = g_stage[k-1].vld_q;
        m_src = g_stage[k-1].mode_q;
        a_src = g_stage[k-1].g_fwd.a_q;
        b_src = g_stage[k-1].g_fwd.b_q;
        c_src = g_stage[k-1].cy_q;
      end
      assign sum_d = {slice_sum, g_stage[k-1].sum_q};
    end

    chunk_adder #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a_i    (a_src[CHUNK-1:0]),
      .b_i    (b_src[CHUNK-1:0]),
      .cin_i  (c_src),
      .sum_o  (slice_sum),
      .cout_o (slice_cout)
    );

    always_comb begin
      vld_d  = v_src;
      mode_d = m_src;
      cy_d   = slice_cout;
    end

    // Data only loads behind a valid token, so bubbles leave the last result in place.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        mode_q <= MODE_ADD;
        cy_q   <= 1'b0;
        sum_q  <= '0;
      end else if (advance) begin
        vld_q <= vld_d;
        if (vld_d) begin
          mode_q <= mode_d;
          cy_q   <= cy_d;
          sum_q  <= sum_d;
        end
      end
    end

    if (k < LAST) begin : g_fwd
      logic [RW-CHUNK-1:0] a_d, a_q;
      logic [RW-CHUNK-1:0] b_d, b_q;

      assign a_d = a_src[RW-1:CHUNK];
      assign b_d = b_src[RW-1:CHUNK];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance && vld_d) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic amsb_d, amsb_q;
      logic bmsb_d, bmsb_q;

      // The final slice holds both operand MSBs; keep raw B's sign for overflow.
      assign amsb_d = a_src[CHUNK-1];
      assign bmsb_d = b_src[CHUNK-1] ^ m_src;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amsb_q <= 1'b0;
          bmsb_q <= 1'b0;
        end else if (advance && vld_d) begin
          amsb_q <= amsb_d;
          bmsb_q <= bmsb_d;
        end
      end

      assign out_valid = vld_q;
      assign out_sum   = sum_q;
      assign out_cout  = cy_q;
      assign out_ovf   = vld_q & ovf_f(amsb_q, bmsb_q, sum_q[WIDTH-1], mode_q);
      assign out_zero  = vld_q & (sum_q == '0);
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: a 4-stage and a 1-stage instance are
// exercised in turn against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pipelined_adder;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           pcyc;
    int           snap;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_a, in_b;
  logic         in_cin, in_mode;
  logic         out_ready;
  logic         sel16;

  logic iv4, ir4, ov4, co4, of4, z4;
  logic iv16, ir16, ov16, co16, of16, z16;
  logic [W-1:0] sum4, sum16;

  assign iv4  = in_valid & ~sel16;
  assign iv16 = in_valid & sel16;

  pipelined_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_mode(in_mode),
    .out_valid(ov4), .out_ready(out_ready), .out_sum(sum4),
    .out_cout(co4), .out_ovf(of4), .out_zero(z4)
  );

  pipelined_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_mode(in_mode),
    .out_valid(ov16), .out_ready(out_ready), .out_sum(sum16),
    .out_cout(co16), .out_ovf(of16), .out_zero(z16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   nstall[2];
  int   nout[2];
  int   stall_left = 0;
  exp_t q0[$];
  exp_t q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o, input logic z);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.pcyc = 0; e.snap = 0;
    return e;
  endfunction

  // Reference: plain integer arithmetic; overflow is "signed result out of range".
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic mode);
    longint ua, ub, sa, sb, r, sr, lim;
    logic c;
    logic [W-1:0] s;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    lim = longint'(1) << (W - 1);
    if (mode) begin
      r = ua - ub; sr = sa - sb; c = (ua >= ub);
    end else begin
      r = ua + ub + longint'(cin); sr = sa + sb + longint'(cin);
      c = (r >= (longint'(1) << W));
    end
    s = W'(r);
    return mk(s, c, (sr >= lim) || (sr < -lim), s == '0);
  endfunction

  task automatic mon(input int d, input logic ov, input logic ir, input logic [W-1:0] s,
                     input logic co, input logic of, input logic z);
    exp_t  e;
    int    qs;
    string p;
    if (!ov) return;
    p = (d == 1) ? "dut16" : "dut4";
    nout[d]++;
    qs = (d == 1) ? q1.size() : q0.size();
    if (qs == 0) begin
      checks++; errors++;
      $display("FAIL %s spurious output: got sum=0x%0h, want no output (cycle %0d)", p, s, cyc);
      return;
    end
    e = (d == 1) ? q1[0] : q0[0];
    chk({p, " sum"}, 32'(s), 32'(e.sum));
    chk({p, " cout"}, 32'(co), 32'(e.cout));
    chk({p, " ovf"}, 32'(of), 32'(e.ovf));
    chk({p, " zero"}, 32'(z), 32'(e.zero));
    if (out_ready) begin
      if (d == 1) void'(q1.pop_front()); else void'(q0.pop_front());
      chk({p, " latency"}, 32'(cyc - e.pcyc), 32'(((d == 1) ? 1 : 4) + nstall[d] - e.snap));
    end else begin
      chk({p, " in_ready during stall"}, 32'(ir), 32'(0));
      nstall[d]++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, ov4, ir4, sum4, co4, of4, z4);
      mon(1, ov16, ir16, sum16, co16, of16, z16);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    out_ready = (stall_left == 0);
    if (stall_left > 0) stall_left--;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic mode, input exp_t e_in);
    exp_t e;
    bit   done;
    e = e_in;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      tick();
      in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_mode = mode;
      #1;
      if (sel16 ? ir16 : ir4) begin
        e.pcyc = cyc;
        e.snap = nstall[sel16];
        if (sel16) q1.push_back(e); else q0.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send timeout: got in_ready=0 for 100 cycles, want 1 (cycle %0d)", cyc);
    end
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] a, b;
      logic cin, mode;
      a = W'($urandom); b = W'($urandom);
      if ($urandom_range(0, 7) == 0) a = '0;
      if ($urandom_range(0, 7) == 0) b = W'(1) << (W - 1);
      cin = 1'($urandom); mode = 1'($urandom);
      if ($urandom_range(0, 7) == 0) stall_left = $urandom_range(1, 4);
      if ($urandom_range(0, 5) == 0) idle(1);
      send(a, b, cin, mode, model(a, b, cin, mode));
    end
  endtask

  task automatic rst_chk(input string p, input logic ov, input logic ir, input logic [W-1:0] s,
                         input logic co, input logic of, input logic z);
    chk({p, " reset out_valid"}, 32'(ov), 32'(0));
    chk({p, " reset in_ready"}, 32'(ir), 32'(1));
    chk({p, " reset out_sum"}, 32'(s), 32'(0));
    chk({p, " reset out_cout"}, 32'(co), 32'(0));
    chk({p, " reset out_ovf"}, 32'(of), 32'(0));
    chk({p, " reset out_zero"}, 32'(z), 32'(0));
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && (q0.size() + q1.size()) > 0; t++) idle(1);
    idle(2);
    chk("drained dut4 queue", 32'(q0.size()), 32'(0));
    chk("drained dut16 queue", 32'(q1.size()), 32'(0));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_mode = 1'b0;
    out_ready = 1'b1; sel16 = 1'b0;
    nstall[0] = 0; nstall[1] = 0; nout[0] = 0; nout[1] = 0;
    repeat (3) @(posedge clk);
    #2;
    rst_chk("dut4", ov4, ir4, sum4, co4, of4, z4);
    rst_chk("dut16", ov16, ir16, sum16, co16, of16, z16);
    rst_n = 1'b1;
    idle(2);

    // Directed boundaries on the 4-stage unit.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
    send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));
    send(16'h0003, 16'h0005, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0));
    send(16'h0003, 16'h0005, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0));
    send(16'h7FFF, 16'h0000, 1'b1, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0));
    idle(6);

    // Back-to-back stream: a=i, b=2i, cin=1 -> 3i+1.
    for (int i = 0; i < 8; i++)
      send(W'(i), W'(2 * i), 1'b1, 1'b0, mk(W'(3 * i + 1), 1'b0, 1'b0, 1'b0));
    idle(6);

    // Stall for 6 cycles mid-stream.
    send_rand(4);
    stall_left = 6;
    send_rand(6);
    idle(12);

    // Reset with three operations in flight.
    send_rand(3);
    idle(1);
    #1;
    rst_n = 1'b0;
    #1;
    rst_chk("dut4 midflight", ov4, ir4, sum4, co4, of4, z4);
    q0.delete();
    nstall[0] = 0;
    nout[0] = 0;
    idle(2);
    rst_n = 1'b1;
    idle(8);
    chk("dut4 no stale result after reset", 32'(nout[0]), 32'(0));

    send_rand(60);
    drain();

    // Single-stage configuration.
    sel16 = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
    send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));
    send(16'h0003, 16'h0005, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0));
    stall_left = 3;
    send_rand(40);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
